uart_imem_loader: RTL and testbench

//  Boot-time program loader upstream of the instruction memory and the cpu core.

---
 rtl/uart_imem_loader.sv | 171 +++++++++++++++++
 tb/tb_uart_imem_loader.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_imem_loader.sv
// Boot loader: 8N1 UART byte stream -> little-endian 32-bit words -> instruction memory.
// Optional trailing XOR checksum byte enabled by defining LOADER_CHECKSUM_EN.
module uart_imem_loader #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int BAUD      = 115200,
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rx,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  localparam int CPB   = CLK_HZ / BAUD;
  localparam int HALF  = CPB / 2;
  localparam int CNT_W = $clog2(CPB);
  localparam int LEN_W = ADDR_W + 1;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_LEN0, S_LEN1, S_DATA, S_CHK, S_DONE, S_ERR} ld_state_t;
  localparam ld_state_t S_FIN = S_CHK;
`else
  typedef enum logic [2:0] {S_LEN0, S_LEN1, S_DATA, S_DONE, S_ERR} ld_state_t;
  localparam ld_state_t S_FIN = S_DONE;
`endif

  // ---------------- UART receiver ----------------
  rx_state_t        rx_st, rx_nxt;
  logic             rx_meta, rx_s, rx_prev;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       rx_sh;
  logic             rx_valid, rx_ferr, cnt_wrap;

  assign cnt_wrap = (rx_st == RX_START) ? (rx_cnt == CNT_W'(HALF - 1))
                                        : (rx_cnt == CNT_W'(CPB - 1));

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    rx_nxt   = rx_st;
    rx_valid = 1'b0;
    rx_ferr  = 1'b0;
    case (rx_st)
      RX_IDLE:  if (rx_prev && !rx_s) rx_nxt = RX_START;
      RX_START: if (cnt_wrap) rx_nxt = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (cnt_wrap && bit_idx == 3'd7) rx_nxt = RX_STOP;
      RX_STOP:  if (cnt_wrap) begin
                  rx_nxt   = RX_IDLE;
                  rx_valid = rx_s;
                  rx_ferr  = !rx_s;
                end
      default:  rx_nxt = RX_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
      rx_st   <= RX_IDLE;
      rx_cnt  <= '0;
      bit_idx <= '0;
      rx_sh   <= '0;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
      rx_st   <= rx_nxt;
      rx_cnt  <= (rx_st == RX_IDLE || cnt_wrap) ? '0 : rx_cnt + 1'b1;
      if (rx_st == RX_IDLE) bit_idx <= '0;
      if (rx_st == RX_DATA && cnt_wrap) begin
        rx_sh   <= {rx_s, rx_sh[7:1]};
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

  // ---------------- Load protocol ----------------
  ld_state_t        st, st_nxt;
  logic [7:0]       len_lo;
  logic [LEN_W-1:0] len_q;
  logic [1:0]       byte_idx;
  logic [15:0]      len_full;
  logic             last_word, reload_go;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]       chk;
`endif

  assign len_full  = {rx_sh, len_lo};
  assign last_word = ({1'b0, imem_addr} == len_q - LEN_W'(1));
  assign reload_go = reload && (st == S_DONE || st == S_ERR);

  always_comb begin
    st_nxt = st;
    case (st)
      S_LEN0: if (rx_valid) st_nxt = S_LEN1;
      S_LEN1: if (rx_valid) begin
                if (len_full > 16'(MAX_WORDS)) st_nxt = S_ERR;
                else if (len_full != 16'd0)    st_nxt = S_DATA;
                else                           st_nxt = S_FIN;
              end
      S_DATA: if (rx_valid && byte_idx == 2'd3 && last_word) st_nxt = S_FIN;
`ifdef LOADER_CHECKSUM_EN
      S_CHK:  if (rx_valid) st_nxt = (rx_sh == chk) ? S_DONE : S_ERR;
`endif
      S_DONE, S_ERR: if (reload) st_nxt = S_LEN0;
      default: st_nxt = S_ERR;
    endcase
    // A framing error aborts any load in progress; finished states ignore the line.
    if (rx_ferr && st != S_DONE && st != S_ERR) st_nxt = S_ERR;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st         <= S_LEN0;
      len_lo     <= '0;
      len_q      <= '0;
      byte_idx   <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
`ifdef LOADER_CHECKSUM_EN
      chk        <= '0;
`endif
    end else begin
      st      <= st_nxt;
      imem_we <= 1'b0;
      // Advance only while more words follow, so the final address stays at len-1.
      if (imem_we && st == S_DATA) imem_addr <= imem_addr + 1'b1;
      if (reload_go) begin
        imem_addr <= '0;
        byte_idx  <= '0;
`ifdef LOADER_CHECKSUM_EN
        chk       <= '0;
`endif
      end else if (rx_valid && (st == S_LEN0 || st == S_LEN1 || st == S_DATA)) begin
`ifdef LOADER_CHECKSUM_EN
        chk <= chk ^ rx_sh;
`endif
        case (st)
          S_LEN0: len_lo <= rx_sh;
          S_LEN1: begin
                    len_q    <= LEN_W'(len_full);
                    byte_idx <= '0;
                  end
          default: begin
                    imem_wdata[{byte_idx, 3'b000} +: 8] <= rx_sh;
                    byte_idx <= byte_idx + 1'b1;
                    if (byte_idx == 2'd3) imem_we <= 1'b1;
                  end
        endcase
      end
    end
  end

  assign load_done = (st == S_DONE);
  assign load_err  = (st == S_ERR);
  assign cpu_hold  = (st != S_DONE);

endmodule

// File: tb/tb_uart_imem_loader.sv
// Bench for uart_imem_loader: directed UART images, write scoreboard, status checks.
// Follows LOADER_CHECKSUM_EN to append/expect the checksum byte.
module tb_uart_imem_loader;

  localparam int CPB = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        uart_rx = 1'b1;
  logic        reload = 1'b0;
  logic        imem_we;
  logic [3:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold, load_done, load_err;

  always #5 clk = ~clk;

  uart_imem_loader #(
    .CLK_HZ(1_000_000), .BAUD(100_000), .ADDR_W(4), .MAX_WORDS(16)
  ) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .reload(reload),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err)
  );

  typedef struct packed {
    logic [3:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t        sb[$];
  int         n_pass  = 0;
  int         n_total = 0;
  logic [7:0] tb_chk;
  logic       prev_we = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every write strobe must match the oldest expected write and last one cycle.
  always @(negedge clk) begin
    if (imem_we) begin
      check("we_one_cycle", 32'(prev_we), 32'd0);
      if (sb.size() == 0) begin
        check("write_expected", 32'(sb.size()), 32'd1);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("wr_addr", 32'(imem_addr), 32'(e.addr));
        check("wr_data", imem_wdata, e.data);
      end
    end
    prev_we = imem_we;
  end

  task automatic check_status(input string name, input logic done, input logic err, input logic hold);
    check({name, "_done"}, 32'(load_done), 32'(done));
    check({name, "_err"},  32'(load_err),  32'(err));
    check({name, "_hold"}, 32'(cpu_hold),  32'(hold));
  endtask

  task automatic check_reset_values(input string name);
    check_status(name, 1'b0, 1'b0, 1'b1);
    check({name, "_we"},    32'(imem_we),   32'd0);
    check({name, "_addr"},  32'(imem_addr), 32'd0);
    check({name, "_wdata"}, imem_wdata,     32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    @(negedge clk) uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (CPB) @(negedge clk);
    tb_chk ^= b;
  endtask

  task automatic send_word(input logic [3:0] addr, input logic [31:0] data);
    sb.push_back('{addr: addr, data: data});
    for (int i = 0; i < 4; i++) send_byte(data[8*i +: 8]);
  endtask

  task automatic send_chk();
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] c;
    c = tb_chk;
    send_byte(c);
`endif
  endtask

  task automatic pulse_reload();
    @(negedge clk) reload = 1'b1;
    @(negedge clk) reload = 1'b0;
  endtask

  task automatic settle();
    repeat (20) @(negedge clk);
  endtask

  initial begin
    // Reset state and idle line
    repeat (5) @(negedge clk);
    check_reset_values("in_reset");
    rst = 1'b1;
    repeat (200) @(negedge clk);
    check_status("idle", 1'b0, 1'b0, 1'b1);

    // Two-word image
    tb_chk = 8'h00;
    send_byte(8'h02); send_byte(8'h00);
    send_word(4'd0, 32'h12345678);
    send_word(4'd1, 32'hDEADBEEF);
    send_chk();
    settle();
    check_status("image", 1'b1, 1'b0, 1'b0);
    check("image_drained", 32'(sb.size()), 32'd0);

    // Bytes after DONE are ignored; reload returns to hold
    send_byte(8'h55);
    settle();
    check_status("done_ignore", 1'b1, 1'b0, 1'b0);
    pulse_reload();
    check_status("reload_from_done", 1'b0, 1'b0, 1'b1);
    check("reload_addr", 32'(imem_addr), 32'd0);

    // Length 17 > 16 -> error, then reload and empty image
    tb_chk = 8'h00;
    send_byte(8'h11); send_byte(8'h00);
    settle();
    check_status("too_long", 1'b0, 1'b1, 1'b1);
    pulse_reload();
    check_status("reload_from_err", 1'b0, 1'b0, 1'b1);
    tb_chk = 8'h00;
    send_byte(8'h00); send_byte(8'h00);
    send_chk();
    settle();
    check_status("empty_image", 1'b1, 1'b0, 1'b0);

    // Framing error in DATA
    pulse_reload();
    tb_chk = 8'h00;
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hA5, 1'b0);
    settle();
    check_status("framing", 1'b0, 1'b1, 1'b1);
    pulse_reload();

    // Short low glitch on idle line must not produce a byte
    @(negedge clk) uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    repeat (200) @(negedge clk);
    check_status("glitch", 1'b0, 1'b0, 1'b1);
    tb_chk = 8'h00;
    send_byte(8'h01); send_byte(8'h00);
    send_word(4'd0, 32'hCAFEF00D);
    send_chk();
    settle();
    check_status("after_glitch", 1'b1, 1'b0, 1'b0);
    check("glitch_drained", 32'(sb.size()), 32'd0);

    // Reset in the middle of word 1
    pulse_reload();
    tb_chk = 8'h00;
    send_byte(8'h02); send_byte(8'h00);
    send_word(4'd0, 32'h0BADC0DE);
    send_byte(8'h11); send_byte(8'h22);
    @(negedge clk) uart_rx = 1'b0;
    repeat (35) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("mid_reset");
    uart_rx = 1'b1;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    repeat (50) @(negedge clk);

    // Full reload from LEN0; a reload pulse while in LEN1 is ignored
    tb_chk = 8'h00;
    send_byte(8'h02);
    pulse_reload();
    send_byte(8'h00);
    send_word(4'd0, 32'hA1B2C3D4);
    send_word(4'd1, 32'h55AA0FF0);
    send_chk();
    settle();
    check_status("after_reset", 1'b1, 1'b0, 1'b0);
    check("reset_drained", 32'(sb.size()), 32'd0);

`ifdef LOADER_CHECKSUM_EN
    // Correct data, wrong checksum: words land, then error
    pulse_reload();
    tb_chk = 8'h00;
    send_byte(8'h01); send_byte(8'h00);
    send_word(4'd0, 32'h01020304);
    send_byte(8'hFF);
    settle();
    check_status("bad_chk", 1'b0, 1'b1, 1'b1);
    check("bad_chk_drained", 32'(sb.size()), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
